// File: rtl/ibex_multdiv_issue.sv
// Issue and result-buffer stage in front of ibex_multdiv_slow: latches one
// request, drives the multdiv controls, owns the intermediate registers and buffers the result.
module ibex_multdiv_issue (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,
    input  logic        flush_i,
    input  logic        rsp_ready_i,
    output logic        mult_en_o,
    output logic        div_en_o,
    output logic        mult_sel_o,
    output logic        div_sel_o,
    output logic [1:0]  operator_o,
    output logic [1:0]  signed_mode_o,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic        multdiv_ready_id_o,
    output logic [67:0] imd_val_q_o,
    input  logic [67:0] imd_val_d_i,
    input  logic [1:0]  imd_val_we_i,
    input  logic        md_valid_i,
    input  logic [31:0] md_result_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_result_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FLUSH = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_capture;
    logic        w_active;
    logic        w_is_div;

    logic [1:0]  r_op;
    logic [1:0]  r_signed_mode;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_result;
    logic [33:0] r_imd0;
    logic [33:0] r_imd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A flush in HOLD blocks acceptance so the dropped slot cannot swallow a new request.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_capture   = 1'b0;
        w_active    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid_i) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_active = 1'b1;
                if (md_valid_i) begin
                    w_capture   = !flush_i;
                    w_state_nxt = flush_i ? S_IDLE : S_HOLD;
                end else if (flush_i) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_active = 1'b1;
                if (md_valid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                w_req_ready = rsp_ready_i & !flush_i;
                if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end else if (rsp_ready_i) begin
                    w_state_nxt = req_valid_i ? S_BUSY : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = req_valid_i & w_req_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op          <= 2'b00;
            r_signed_mode <= 2'b00;
            r_op_a        <= 32'h0;
            r_op_b        <= 32'h0;
        end else if (w_accept) begin
            r_op          <= req_op_i;
            r_signed_mode <= req_signed_mode_i;
            r_op_a        <= req_op_a_i;
            r_op_b        <= req_op_b_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result <= 32'h0;
        end else if (w_capture) begin
            r_result <= md_result_i;
        end
    end

    // Intermediate values belong to the multdiv datapath; flush must not touch them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_imd0 <= 34'h0;
            r_imd1 <= 34'h0;
        end else begin
            if (imd_val_we_i[0]) begin
                r_imd0 <= imd_val_d_i[33:0];
            end
            if (imd_val_we_i[1]) begin
                r_imd1 <= imd_val_d_i[67:34];
            end
        end
    end

    assign w_is_div = r_op[1];

    // Controls derive only from registered state, so req_* never reaches the enables.
    assign mult_en_o          = w_active & ~w_is_div;
    assign mult_sel_o         = w_active & ~w_is_div;
    assign div_en_o           = w_active & w_is_div;
    assign div_sel_o          = w_active & w_is_div;
    assign multdiv_ready_id_o = w_active;

    assign req_ready_o   = w_req_ready;
    assign operator_o    = r_op;
    assign signed_mode_o = r_signed_mode;
    assign op_a_o        = r_op_a;
    assign op_b_o        = r_op_b;
    assign imd_val_q_o   = {r_imd1, r_imd0};
    assign rsp_valid_o   = (r_state == S_HOLD);
    assign rsp_result_o  = r_result;
    assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Bench for ibex_multdiv_issue: a 4-cycle multdiv stub, a vector table,
// hand-written flush/back-to-back/reset sequences and randomized transactions.
module tb_ibex_multdiv_issue;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready_o;
    logic [1:0]  req_op;
    logic [1:0]  req_sm;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        rsp_ready;
    logic        mult_en_o;
    logic        div_en_o;
    logic        mult_sel_o;
    logic        div_sel_o;
    logic [1:0]  operator_o;
    logic [1:0]  signed_mode_o;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic        multdiv_ready_id_o;
    logic [67:0] imd_val_q_o;
    logic [67:0] imd_val_d;
    logic [1:0]  imd_val_we;
    logic        md_valid;
    logic [31:0] md_result;
    logic        rsp_valid_o;
    logic [31:0] rsp_result_o;
    logic        busy_o;

    logic        md_force;
    logic [3:0]  stub_cnt;

    int checks;
    int failures;

    ibex_multdiv_issue dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready_o),
        .req_op_i           (req_op),
        .req_signed_mode_i  (req_sm),
        .req_op_a_i         (req_a),
        .req_op_b_i         (req_b),
        .flush_i            (flush),
        .rsp_ready_i        (rsp_ready),
        .mult_en_o          (mult_en_o),
        .div_en_o           (div_en_o),
        .mult_sel_o         (mult_sel_o),
        .div_sel_o          (div_sel_o),
        .operator_o         (operator_o),
        .signed_mode_o      (signed_mode_o),
        .op_a_o             (op_a_o),
        .op_b_o             (op_b_o),
        .multdiv_ready_id_o (multdiv_ready_id_o),
        .imd_val_q_o        (imd_val_q_o),
        .imd_val_d_i        (imd_val_d),
        .imd_val_we_i       (imd_val_we),
        .md_valid_i         (md_valid),
        .md_result_i        (md_result),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_result_o       (rsp_result_o),
        .busy_o             (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V M-extension semantics from plain arithmetic on 33-bit extended operands.
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [1:0] sm,
                                            input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] ea, eb, p;
        logic signed [32:0] sa, sb, q, r;
        ea = {{34{sm[0] & a[31]}}, a};
        eb = {{34{sm[1] & b[31]}}, b};
        p  = ea * eb;
        sa = {sm[0] & a[31], a};
        sb = {sm[1] & b[31], b};
        q  = (b == 32'h0) ? 33'sh0 : sa / sb;
        r  = (b == 32'h0) ? 33'sh0 : sa % sb;
        case (op)
            2'd0:    ref_res = p[31:0];
            2'd1:    ref_res = p[63:32];
            2'd2:    ref_res = (b == 32'h0) ? 32'hFFFF_FFFF : q[31:0];
            default: ref_res = (b == 32'h0) ? a : r[31:0];
        endcase
    endfunction

    // Multdiv stub: result valid in the 4th cycle the enable is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt <= 4'd0;
        end else if (mult_en_o | div_en_o) begin
            stub_cnt <= stub_cnt + 4'd1;
        end else begin
            stub_cnt <= 4'd0;
        end
    end
    assign md_valid  = ((mult_en_o | div_en_o) && stub_cnt == 4'd3) || md_force;
    assign md_result = md_force ? 32'hDEAD_BEEF : ref_res(operator_o, signed_mode_o, op_a_o, op_b_o);

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_sm    = sm;
        req_a     = a;
        req_b     = b;
        #1;
        chk("issue_ready", req_ready_o, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("latch", {operator_o, signed_mode_o, op_a_o, op_b_o}, {op, sm, a, b});
        chk("busy_ctrl", {busy_o, mult_en_o, mult_sel_o, div_en_o, div_sel_o, multdiv_ready_id_o},
            {1'b1, ~op[1], ~op[1], op[1], op[1], 1'b1});
    endtask

    // Called at the negedge of the first enabled cycle; returns in HOLD.
    task automatic wait_hold(input string nm, input logic [31:0] exp);
        int en;
        en = 0;
        for (int i = 0; i < 30 && !rsp_valid_o; i++) begin
            if (mult_en_o | div_en_o) en++;
            @(negedge clk);
        end
        chk("rsp_timeout", rsp_valid_o, 1'b1);
        chk("en_cycles", en, 4);
        chk(nm, rsp_result_o, exp);
        chk("hold_ctrl", {mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o, req_ready_o},
            6'b0);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("drained", {busy_o, rsp_valid_o, req_ready_o}, 3'b001);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int bad;
        int en;
        logic [1:0]  rop, rsm;
        logic [31:0] ra, rb, rexp;

        checks = 0; failures = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_sm = 2'd0; req_a = 32'h0; req_b = 32'h0;
        flush = 1'b0; rsp_ready = 1'b0; imd_val_d = 68'h0; imd_val_we = 2'b00; md_force = 1'b0;

        vecs[0] = '{2'd0, 2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        vecs[1] = '{2'd2, 2'b11, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA};
        vecs[2] = '{2'd3, 2'b11, 32'h0000_0014, 32'h0000_0003, 32'h0000_0002};
        vecs[3] = '{2'd2, 2'b00, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[4] = '{2'd3, 2'b00, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
        vecs[5] = '{2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[6] = '{2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[7] = '{2'd1, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};

        #12;
        chk("reset_vals", {req_ready_o, busy_o, rsp_valid_o, mult_en_o, div_en_o, mult_sel_o,
            div_sel_o, multdiv_ready_id_o, operator_o, signed_mode_o, op_a_o, op_b_o,
            rsp_result_o, imd_val_q_o}, {1'b1, 175'h0});
        @(negedge clk);
        rst_n = 1'b1;

        // Intermediate register write enables are independent.
        @(negedge clk);
        imd_val_d  = {34'h3_0000_0001, 34'h0_0000_1234};
        imd_val_we = 2'b10;
        @(negedge clk);
        imd_val_we = 2'b00;
        chk("imd_we10", imd_val_q_o, {34'h3_0000_0001, 34'h0});

        // md_valid in IDLE is ignored.
        md_force = 1'b1;
        @(negedge clk);
        md_force = 1'b0;
        chk("mdv_idle", {busy_o, rsp_valid_o, rsp_result_o}, 34'h0);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].sm, vecs[i].a, vecs[i].b);
            wait_hold("vec_result", vecs[i].exp);
            drain();
        end

        // MULL held 3 cycles with a spurious md_valid: result unchanged.
        issue(2'd0, 2'b00, 32'h7, 32'h6);
        wait_hold("mull", 32'h2A);
        md_force = 1'b1;
        repeat (3) @(negedge clk);
        md_force = 1'b0;
        chk("mull_hold", {rsp_valid_o, rsp_result_o}, {1'b1, 32'h2A});
        drain();

        // Back-to-back handoff from HOLD.
        issue(2'd2, 2'b11, 32'hFFFF_FFEC, 32'h3);
        wait_hold("div_s", 32'hFFFF_FFFA);
        rsp_ready = 1'b1; req_valid = 1'b1; req_op = 2'd3; req_sm = 2'b11; req_a = 32'd20; req_b = 32'd3;
        #1;
        chk("b2b_ready", req_ready_o, 1'b1);
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        chk("b2b_nobubble", {busy_o, div_en_o, rsp_valid_o}, 3'b110);
        wait_hold("rem_b2b", 32'h2);
        drain();

        // Flush two cycles into BUSY.
        issue(2'd0, 2'b00, 32'h3, 32'h4);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bad = 0; en = 2;
        for (int i = 0; i < 30 && busy_o; i++) begin
            if (!mult_en_o || !multdiv_ready_id_o || req_ready_o || rsp_valid_o) bad++;
            en++;
            @(negedge clk);
        end
        chk("flush_ctrl", bad, 0);
        chk("flush_en_cycles", en, 4);
        chk("flush_idle", {busy_o, rsp_valid_o, req_ready_o}, 3'b001);

        // Flush coincident with md_valid.
        issue(2'd2, 2'b00, 32'd100, 32'd7);
        for (int i = 0; i < 30 && !md_valid; i++) @(negedge clk);
        chk("fv_mdvalid", md_valid, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", {busy_o, rsp_valid_o, req_ready_o}, 3'b001);
        @(negedge clk);
        chk("flush_valid_norsp", {busy_o, rsp_valid_o}, 2'b00);

        // Flush in HOLD beats both rsp_ready and a new request.
        issue(2'd0, 2'b00, 32'd5, 32'd5);
        wait_hold("mul25", 32'd25);
        flush = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_op = 2'd2; req_a = 32'd1; req_b = 32'd1;
        #1;
        chk("hold_flush_ready", req_ready_o, 1'b0);
        @(negedge clk);
        flush = 1'b0; rsp_ready = 1'b0; req_valid = 1'b0;
        chk("hold_flush", {busy_o, rsp_valid_o, operator_o, op_a_o}, {2'b00, 2'd0, 32'd5});
        chk("imd_kept", imd_val_q_o, {34'h3_0000_0001, 34'h0});

        // Randomized transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            rsm = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 9)));
            rexp = ref_res(rop, rsm, ra, rb);
            issue(rop, rsm, ra, rb);
            wait_hold("rand_result", rexp);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            chk("rand_hold", {rsp_valid_o, rsp_result_o}, {1'b1, rexp});
            drain();
        end

        // Asynchronous reset in the middle of BUSY.
        imd_val_d  = {34'h1_0000_0000, 34'h2_AAAA_5555};
        imd_val_we = 2'b01;
        issue(2'd3, 2'b11, 32'h1234_5678, 32'h9);
        imd_val_we = 2'b00;
        chk("imd_we01_busy", imd_val_q_o, {34'h3_0000_0001, 34'h2_AAAA_5555});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {req_ready_o, busy_o, rsp_valid_o, mult_en_o, div_en_o, mult_sel_o,
            div_sel_o, multdiv_ready_id_o, operator_o, signed_mode_o, op_a_o, op_b_o,
            rsp_result_o, imd_val_q_o}, {1'b1, 175'h0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
